// File: rtl/stream_traffic_gen.sv
// Stream traffic generator and checker for a lane-wise increment operator.
// The TX side sends a counting lane pattern, and the RX side checks that each lane returns as sent value + INC.
module stream_traffic_gen #(
  parameter int          PAYLOAD_BITS   = 512,
  parameter int          LANE_BITS      = 32,
  parameter logic [31:0] INC            = 32'd1,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  input  logic [31:0]             num_words,
  input  logic [31:0]             base,
  output logic [PAYLOAD_BITS-1:0] Output_1_TDATA,
  output logic                    Output_1_TVALID,
  input  logic                    Output_1_TREADY,
  input  logic [PAYLOAD_BITS-1:0] Input_1_TDATA,
  input  logic                    Input_1_TVALID,
  output logic                    Input_1_TREADY,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic [31:0]             tx_count,
  output logic [31:0]             rx_count,
  output logic [31:0]             err_count,
  output logic                    timeout
);

  localparam int LANES   = PAYLOAD_BITS / LANE_BITS;
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [31:0]             num_q;
  logic [31:0]             base_q;
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_valid;
  logic [WD_BITS-1:0]      wd;

  logic                    tx_hs;
  logic                    rx_hs;
  logic                    rx_bad;
  logic                    all_done;
  logic [LANE_BITS-1:0]    exp_lane0;
  logic [PAYLOAD_BITS-1:0] next_word;

  // First word of a run: lane k = first + k.
  function automatic logic [PAYLOAD_BITS-1:0] lane_seq(input logic [31:0] first);
    logic [PAYLOAD_BITS-1:0] w;
    for (int k = 0; k < LANES; k++)
      w[k*LANE_BITS +: LANE_BITS] = LANE_BITS'(first) + LANE_BITS'(k);
    return w;
  endfunction

  assign tx_hs    = tx_valid && Output_1_TREADY;
  assign rx_hs    = Input_1_TVALID && Input_1_TREADY;
  assign all_done = (tx_count == num_q) && (rx_count == num_q);

  assign Input_1_TREADY  = (state == S_RUN) && (rx_count < num_q);
  assign Output_1_TDATA  = tx_data;
  assign Output_1_TVALID = tx_valid;
  assign ap_idle         = (state == S_IDLE);
  assign ap_done         = (state == S_DONE);

  // Expected RX word is rebuilt from base and index, so no copy of sent data is kept.
  assign exp_lane0 = LANE_BITS'(base_q + rx_count * 32'(LANES) + INC);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rx_bad    = 1'b0;
    next_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (Input_1_TDATA[k*LANE_BITS +: LANE_BITS] != exp_lane0 + LANE_BITS'(k))
        rx_bad = 1'b1;
      next_word[k*LANE_BITS +: LANE_BITS] =
        tx_data[k*LANE_BITS +: LANE_BITS] + LANE_BITS'(LANES);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      num_q     <= '0;
      base_q    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      wd        <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            num_q     <= num_words;
            base_q    <= base;
            tx_data   <= lane_seq(base);
            tx_count  <= '0;
            rx_count  <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
            wd        <= '0;
            if (num_words == 32'd0) begin
              state    <= S_DONE;
              tx_valid <= 1'b0;
            end else begin
              state    <= S_RUN;
              tx_valid <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (tx_hs) begin
            tx_count <= tx_count + 32'd1;
            tx_data  <= next_word;
            tx_valid <= (tx_count + 32'd1 != num_q);
          end
          if (rx_hs) begin
            rx_count <= rx_count + 32'd1;
            if (rx_bad && err_count != 32'hFFFF_FFFF)
              err_count <= err_count + 32'd1;
          end

          if (tx_hs || rx_hs)
            wd <= '0;
          else if (wd != WD_BITS'(TIMEOUT_CYCLES - 1))
            wd <= wd + WD_BITS'(1);

          // The watchdog only fires if the run is not already complete this cycle.
          if (all_done) begin
            state <= S_DONE;
          end else if (!tx_hs && !rx_hs && wd == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
            state    <= S_DONE;
            timeout  <= 1'b1;
            tx_valid <= 1'b0;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
